// File: rtl/md_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : md_unit_if
//  Brief    : E-stage HI/LO unit bus: instruction request, MFHI/MFLO read
//             path, stall and architectural HI/LO outputs.
//  Revision : 1.0  initial release
// ============================================================================
interface md_unit_if;
    logic        en;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rd_hi;
    logic [31:0] rdata;
    logic        busy;
    logic        xstall;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output en, op, a, b, rd_hi,
        input  rdata, busy, xstall, hi, lo
    );

    modport slave (
        input  en, op, a, b, rd_hi,
        output rdata, busy, xstall, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
//  Module   : md_unit
//  Brief    : Multi-cycle multiply/divide unit owning HI/LO; fixed-latency
//             MULT/MULTU/DIV/DIVU, single-cycle MTHI/MTLO, pipeline stall out.
//  Revision : 1.0  initial release
// ============================================================================
module md_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_unit_if.slave   bus
);

    localparam logic [2:0] c_op_mult  = 3'd1;
    localparam logic [2:0] c_op_multu = 3'd2;
    localparam logic [2:0] c_op_div   = 3'd3;
    localparam logic [2:0] c_op_divu  = 3'd4;
    localparam logic [2:0] c_op_mthi  = 3'd5;
    localparam logic [2:0] c_op_mtlo  = 3'd6;

    localparam int c_max_cycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int c_cnt_need   = $clog2(c_max_cycles + 1);
    localparam int c_cnt_w      = (c_cnt_need > 4) ? c_cnt_need : 4;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state, w_state_n;
    logic [c_cnt_w-1:0]   r_cnt,   w_cnt_n;
    logic [31:0]          r_a,     w_a_n;
    logic [31:0]          r_b,     w_b_n;
    logic [2:0]           r_op,    w_op_n;
    logic [31:0]          r_hi,    w_hi_n;
    logic [31:0]          r_lo,    w_lo_n;

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_div_signed;
    logic        w_neg_a;
    logic        w_neg_b;
    logic [31:0] w_dvd;
    logic [31:0] w_dvs;
    logic [31:0] w_uquo;
    logic [31:0] w_urem;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic        w_start;

    // Low 64 bits of the sign-extended product equal the signed 64-bit product.
    assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

    // One unsigned divider on magnitudes; signs are restored afterwards so the
    // 0x80000000 / -1 case naturally yields quotient 0x80000000, remainder 0.
    assign w_div_signed = (r_op == c_op_div);
    assign w_neg_a      = w_div_signed & r_a[31];
    assign w_neg_b      = w_div_signed & r_b[31];
    assign w_dvd        = w_neg_a ? (~r_a + 32'd1) : r_a;
    assign w_dvs        = w_neg_b ? (~r_b + 32'd1) : r_b;
    assign w_uquo       = (w_dvs != 32'd0) ? (w_dvd / w_dvs) : 32'd0;
    assign w_urem       = (w_dvs != 32'd0) ? (w_dvd % w_dvs) : 32'd0;
    assign w_quo        = (w_neg_a ^ w_neg_b) ? (~w_uquo + 32'd1) : w_uquo;
    assign w_rem        = w_neg_a ? (~w_urem + 32'd1) : w_urem;

    assign w_start    = bus.en & (bus.op >= c_op_mult) & (bus.op <= c_op_divu);
    assign bus.busy   = (r_state == S_RUN);
    assign bus.xstall = bus.busy | w_start;
    assign bus.rdata  = bus.rd_hi ? r_hi : r_lo;
    assign bus.hi     = r_hi;
    assign bus.lo     = r_lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_a     <= w_a_n;
            r_b     <= w_b_n;
            r_op    <= w_op_n;
            r_hi    <= w_hi_n;
            r_lo    <= w_lo_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_a_n     = r_a;
        w_b_n     = r_b;
        w_op_n    = r_op;
        w_hi_n    = r_hi;
        w_lo_n    = r_lo;
        case (r_state)
            S_IDLE: begin
                if (bus.en) begin
                    case (bus.op)
                        c_op_mult, c_op_multu: begin
                            w_a_n     = bus.a;
                            w_b_n     = bus.b;
                            w_op_n    = bus.op;
                            w_cnt_n   = c_cnt_w'(MUL_CYCLES);
                            w_state_n = S_RUN;
                        end
                        c_op_div, c_op_divu: begin
                            w_a_n     = bus.a;
                            w_b_n     = bus.b;
                            w_op_n    = bus.op;
                            w_cnt_n   = c_cnt_w'(DIV_CYCLES);
                            w_state_n = S_RUN;
                        end
                        c_op_mthi: w_hi_n = bus.a;
                        c_op_mtlo: w_lo_n = bus.a;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                // Requests arriving while running are dropped on purpose.
                w_cnt_n = r_cnt - c_cnt_w'(1);
                if (r_cnt == c_cnt_w'(1)) begin
                    w_state_n = S_IDLE;
                    case (r_op)
                        c_op_mult:  {w_hi_n, w_lo_n} = w_prod_s;
                        c_op_multu: {w_hi_n, w_lo_n} = w_prod_u;
                        c_op_div, c_op_divu: begin
                            if (r_b != 32'd0) begin
                                w_hi_n = w_rem;
                                w_lo_n = w_quo;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_md_unit
//  Brief    : Scoreboard bench for md_unit against an arithmetic HI/LO model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_md_unit;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic clk;
    logic reset;
    md_unit_if bus();

    md_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_hi  = 32'd0;
    logic [31:0] m_lo  = 32'd0;
    bit          aborting = 1'b0;
    bit          prev_busy = 1'b0;
    int          run_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Reference: results straight from the architectural definition.
    task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint          sp, sq, sr;
        longint unsigned up;
        case (o)
            3'd1: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                m_hi = sp[63:32]; m_lo = sp[31:0];
            end
            3'd2: begin
                up = longint'({32'd0, x}) * longint'({32'd0, y});
                m_hi = up[63:32]; m_lo = up[31:0];
            end
            3'd3: if (y != 0) begin
                sq = longint'($signed(x)) / longint'($signed(y));
                sr = longint'($signed(x)) % longint'($signed(y));
                m_lo = sq[31:0]; m_hi = sr[31:0];
            end
            3'd4: if (y != 0) begin
                m_lo = x / y; m_hi = x % y;
            end
            3'd5: m_hi = x;
            3'd6: m_lo = x;
            default: ;
        endcase
    endtask

    task automatic sync();
        @(posedge clk); #1;
    endtask

    // Called one time unit after a rising edge with the unit idle.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        bit   is_md;
        exp_t e;
        is_md = (o >= 3'd1) && (o <= 3'd4);
        bus.en = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        #1;
        chk("xstall_at_issue", bus.xstall, is_md);
        model(o, x, y);
        if (is_md) begin
            e.hi = m_hi; e.lo = m_lo; e.lat = (o <= 3'd2) ? MUL_N : DIV_N;
            sb.push_back(e);
        end
        sync();
        bus.en = 1'b0; bus.op = 3'd0;
        chk("busy_after_start", bus.busy, is_md);
        if (!is_md) begin
            chk("hi_after_single", bus.hi, m_hi);
            chk("lo_after_single", bus.lo, m_lo);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (bus.busy === 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("idle_reached", bus.busy, 1'b0);
        sync();
    endtask

    task automatic check_regs();
        bus.rd_hi = 1'b1; #1;
        chk("rdata_hi", bus.rdata, m_hi);
        bus.rd_hi = 1'b0; #1;
        chk("rdata_lo", bus.rdata, m_lo);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: each falling busy marks a completion to match against the queue.
    always @(negedge clk) begin
        exp_t e;
        if (bus.busy === 1'b1) begin
            run_cnt++;
        end else if (prev_busy) begin
            if (!aborting) begin
                if (sb.size() == 0) begin
                    chk("unexpected_completion", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_hi", bus.hi, e.hi);
                    chk("sb_lo", bus.lo, e.lo);
                    chk("sb_busy_cycles", run_cnt, e.lat);
                end
            end
            run_cnt = 0;
        end
        prev_busy = (bus.busy === 1'b1);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.en = 1'b1; bus.op = 3'd1; bus.a = 32'h1234_5678; bus.b = 32'h0000_0005;
        bus.rd_hi = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; bus.en = 1'b0; bus.op = 3'd0;
        @(negedge clk);
        chk("reset_hi", bus.hi, 0);
        chk("reset_lo", bus.lo, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_xstall", bus.xstall, 0);
        sync();

        issue(3'd1, 32'hFFFF_FFFE, 32'd3);           wait_idle(); check_regs();
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);   wait_idle(); check_regs();
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);           wait_idle(); check_regs();
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);   wait_idle(); check_regs();

        // Divide by zero, plus an MTLO slipped in while running.
        issue(3'd4, 32'd7, 32'd0);
        bus.en = 1'b1; bus.op = 3'd6; bus.a = 32'hDEAD_BEEF;
        sync();
        bus.en = 1'b0; bus.op = 3'd0;
        chk("lo_mid_run_mtlo", bus.lo, m_lo);
        wait_idle(); check_regs();

        issue(3'd5, 32'h1234_5678, 32'd0);
        issue(3'd6, 32'h9ABC_DEF0, 32'd0);
        check_regs();

        // Abort a divide with reset in its fourth busy cycle.
        issue(3'd3, 32'd100, 32'd7);
        repeat (3) sync();
        reset = 1'b1; aborting = 1'b1;
        sync();
        reset = 1'b0;
        void'(sb.pop_back());
        m_hi = 32'd0; m_lo = 32'd0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_hi", bus.hi, 0);
        chk("abort_lo", bus.lo, 0);
        repeat (12) sync();
        aborting = 1'b0;
        check_regs();

        for (int i = 0; i < 60; i++) begin
            logic [2:0]  o;
            logic [31:0] x, y;
            o = 3'($urandom_range(0, 7));
            x = pick();
            y = pick();
            issue(o, x, y);
            wait_idle();
            check_regs();
        end

        wait_idle();
        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
